kv_csa_acc_ctrl: RTL and testbench

//  Iterative multi-operand accumulator built around one shared 3:2 carry-save stage.

---
 rtl/kv_csa_acc_ctrl.sv | 175 +++++++++++++++++
 tb/tb_kv_csa_acc_ctrl.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/kv_csa_acc_ctrl.sv
// Multi-operand accumulator: one shared 3:2 carry-save stage folds streamed operands, then one CPA resolves.
// Optional macro KV_CSA_ACC_OVF_EN widens the redundant pair and adds the out_ovf port.
module kv_csa_acc_ctrl #(
  parameter int WIDTH   = 32,
  parameter int MAX_OPS = 16,
  parameter int CNT_W   = $clog2(MAX_OPS + 1)
) (
  input  logic             core_clk,
  input  logic             core_reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic             kill,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_cnt
`ifdef KV_CSA_ACC_OVF_EN
  ,
  output logic             out_ovf
`endif
);

`ifdef KV_CSA_ACC_OVF_EN
  // Headroom for MAX_OPS full-scale operands keeps the redundant pair exact.
  localparam int AW = WIDTH + CNT_W;
`else
  localparam int AW = WIDTH;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ACCUM   = 2'd1,
    RESOLVE = 2'd2,
    DONE    = 2'd3
  } state_t;

  function automatic logic [AW-1:0] csa_sum(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                            input logic [AW-1:0] c);
    return a ^ b ^ c;
  endfunction

  function automatic logic [AW-1:0] csa_carry(input logic [AW-1:0] a, input logic [AW-1:0] b,
                                              input logic [AW-1:0] c);
    logic [AW-1:0] co;
    co = (a & b) | (a & c) | (b & c);
    return {co[AW-2:0], 1'b0};
  endfunction

  state_t           state_q, state_d;
  logic [AW-1:0]    sum_q, sum_d;
  logic [AW-1:0]    carry_q, carry_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_ready_q, in_ready_d;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_data_q, out_data_d;
  logic [CNT_W-1:0] out_cnt_q, out_cnt_d;
  logic             ovf_q, ovf_d;

  logic             in_fire;
  logic [AW-1:0]    op_ext;
  logic [AW-1:0]    total;
  logic [CNT_W-1:0] cnt_inc;

  always_comb begin
    in_fire     = in_valid & in_ready_q;
    op_ext      = AW'(in_data);
    total       = sum_q + carry_q;
    cnt_inc     = cnt_q + CNT_W'(1);

    state_d     = state_q;
    sum_d       = sum_q;
    carry_d     = carry_q;
    cnt_d       = cnt_q;
    out_data_d  = out_data_q;
    out_cnt_d   = out_cnt_q;
    ovf_d       = ovf_q;

    if (kill) begin
      state_d = IDLE;
      sum_d   = '0;
      carry_d = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_fire) begin
            sum_d   = op_ext;
            carry_d = '0;
            cnt_d   = CNT_W'(1);
            state_d = in_last ? RESOLVE : ACCUM;
          end else begin
            state_d = IDLE;
          end
        end
        ACCUM: begin
          if (in_fire) begin
            sum_d   = csa_sum(sum_q, carry_q, op_ext);
            carry_d = csa_carry(sum_q, carry_q, op_ext);
            cnt_d   = cnt_inc;
            if (in_last || (cnt_inc == CNT_W'(MAX_OPS))) begin
              state_d = RESOLVE;
            end else begin
              state_d = ACCUM;
            end
          end else begin
            state_d = ACCUM;
          end
        end
        RESOLVE: begin
          out_data_d = total[WIDTH-1:0];
          out_cnt_d  = cnt_q;
`ifdef KV_CSA_ACC_OVF_EN
          ovf_d      = |total[AW-1:WIDTH];
`else
          ovf_d      = 1'b0;
`endif
          state_d    = DONE;
        end
        DONE: begin
          if (out_ready) begin
            state_d = IDLE;
          end else begin
            state_d = DONE;
          end
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end

    in_ready_d  = (state_d == IDLE) || (state_d == ACCUM);
    out_valid_d = (state_d == DONE);
  end

  // State and registered outputs; reset has priority over kill and every transfer.
  always_ff @(posedge core_clk) begin
    if (core_reset) begin
      state_q     <= IDLE;
      sum_q       <= '0;
      carry_q     <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_cnt_q   <= '0;
      ovf_q       <= 1'b0;
    end else begin
      state_q     <= state_d;
      sum_q       <= sum_d;
      carry_q     <= carry_d;
      cnt_q       <= cnt_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_cnt_q   <= out_cnt_d;
      ovf_q       <= ovf_d;
    end
  end

  // The flop idles high so IDLE is ready right after reset; masking keeps it low during reset.
  assign in_ready  = in_ready_q & ~core_reset;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_cnt   = out_cnt_q;
`ifdef KV_CSA_ACC_OVF_EN
  assign out_ovf   = ovf_q;
`else
  logic unused_ovf;
  assign unused_ovf = ovf_q;
`endif

endmodule

// File: tb/tb_kv_csa_acc_ctrl.sv
// Directed self-checking bench for kv_csa_acc_ctrl (WIDTH=32, MAX_OPS=16).
module tb_kv_csa_acc_ctrl;

  localparam int WIDTH   = 32;
  localparam int MAX_OPS = 16;
  localparam int CNT_W   = 5;

  logic             core_clk;
  logic             core_reset;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] in_data;
  logic             in_last;
  logic             kill;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out_data;
  logic [CNT_W-1:0] out_cnt;
`ifdef KV_CSA_ACC_OVF_EN
  logic             out_ovf;
`endif

  int n_chk;
  int n_fail;

  kv_csa_acc_ctrl #(.WIDTH(WIDTH), .MAX_OPS(MAX_OPS), .CNT_W(CNT_W)) dut (
    .core_clk  (core_clk),
    .core_reset(core_reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .kill      (kill),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_cnt   (out_cnt)
`ifdef KV_CSA_ACC_OVF_EN
    ,
    .out_ovf   (out_ovf)
`endif
  );

  initial core_clk = 1'b0;
  always #5 core_clk = ~core_clk;

  // Advance one cycle; inputs are driven and outputs sampled 1ns after the edge.
  task automatic tick();
    @(posedge core_clk);
    #1;
  endtask

  // Present one operand and hold it until the DUT takes it (bounded).
  task automatic push(input logic [WIDTH-1:0] d, input logic l);
    bit done;
    done     = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    for (int i = 0; i < 100 && !done; i++) begin
      if (in_ready === 1'b1) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    in_last  = 1'b0;
    if (!done) begin
      n_chk++;
      n_fail++;
      $display("FAIL push_timeout: in_ready never 1 for operand %h", d);
    end
  endtask

  // Wait (bounded) for out_valid; expiry counts as a failure.
  task automatic wait_valid(input string tag);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (out_valid === 1'b1) seen = 1'b1;
      else tick();
    end
    if (!seen) begin
      n_chk++;
      n_fail++;
      $display("FAIL %s_valid_timeout: out_valid stayed %b, wanted 1", tag, out_valid);
    end
  endtask

  task automatic test_reset();
    core_reset = 1'b1;
    tick();
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL reset_in_ready: got %b want 0", in_ready); end
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    n_chk++;
    if (out_data !== 32'h0) begin n_fail++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    n_chk++;
    if (out_cnt !== 5'd0) begin n_fail++; $display("FAIL reset_out_cnt: got %0d want 0", out_cnt); end
    core_reset = 1'b0;
    tick();
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_idle_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    out_ready = 1'b1;
    push(32'd3, 1'b0);
    push(32'd5, 1'b0);
    push(32'd7, 1'b1);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_early_valid: got %b want 0 at T+1", out_valid); end
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL basic_resolve_ready: got %b want 0", in_ready); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL basic_latency: out_valid %b want 1 at T+2", out_valid); end
    n_chk++;
    if (out_data !== 32'd15) begin n_fail++; $display("FAIL basic_data: got %0d want 15", out_data); end
    n_chk++;
    if (out_cnt !== 5'd3) begin n_fail++; $display("FAIL basic_cnt: got %0d want 3", out_cnt); end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL basic_handshake: out_valid %b want 0", out_valid); end
    n_chk++;
    if (in_ready !== 1'b1) begin n_fail++; $display("FAIL basic_back_idle: in_ready %b want 1", in_ready); end
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    push(32'hDEADBEEF, 1'b1);
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_early_valid: got %b want 0", out_valid); end
    tick();
    n_chk++;
    if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_latency: out_valid %b want 1", out_valid); end
    n_chk++;
    if (out_data !== 32'hDEADBEEF) begin n_fail++; $display("FAIL single_data: got %h want deadbeef", out_data); end
    n_chk++;
    if (out_cnt !== 5'd1) begin n_fail++; $display("FAIL single_cnt: got %0d want 1", out_cnt); end
    tick();
  endtask

  task automatic test_max_ops();
    out_ready = 1'b0;
    for (int i = 0; i < MAX_OPS; i++) push(32'hFFFFFFFF, 1'b0);
    n_chk++;
    if (in_ready !== 1'b0) begin n_fail++; $display("FAIL max_autoterm: in_ready %b want 0 after %0d ops", in_ready, MAX_OPS); end
    wait_valid("max");
    n_chk++;
    if (out_data !== 32'hFFFFFFF0) begin n_fail++; $display("FAIL max_data: got %h want fffffff0", out_data); end
    n_chk++;
    if (out_cnt !== 5'd16) begin n_fail++; $display("FAIL max_cnt: got %0d want 16", out_cnt); end
`ifdef KV_CSA_ACC_OVF_EN
    n_chk++;
    if (out_ovf !== 1'b1) begin n_fail++; $display("FAIL max_ovf: got %b want 1", out_ovf); end
`endif
    out_ready = 1'b1;
    tick();
    push(32'd1, 1'b0);
    push(32'd1, 1'b1);
    wait_valid("two_ones");
    n_chk++;
    if (out_data !== 32'd2) begin n_fail++; $display("FAIL two_ones_data: got %0d want 2", out_data); end
`ifdef KV_CSA_ACC_OVF_EN
    n_chk++;
    if (out_ovf !== 1'b0) begin n_fail++; $display("FAIL two_ones_ovf: got %b want 0", out_ovf); end
`endif
    tick();
  endtask

  task automatic test_stall_backpressure();
    logic [WIDTH-1:0] vals [4];
    vals[0] = 32'd1; vals[1] = 32'd2; vals[2] = 32'd4; vals[3] = 32'd8;
    out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      for (int g = 0; g < i; g++) tick();
      push(vals[i], (i == 3) ? 1'b1 : 1'b0);
    end
    wait_valid("stall");
    for (int k = 0; k < 5; k++) begin
      n_chk++;
      if (out_valid !== 1'b1 || out_data !== 32'd15 || out_cnt !== 5'd4) begin
        n_fail++;
        $display("FAIL stall_hold%0d: valid %b data %0d cnt %0d want 1/15/4", k, out_valid, out_data, out_cnt);
      end
      tick();
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_single_xfer: out_valid %b want 0", out_valid); end
    tick();
    n_chk++;
    if (out_valid !== 1'b0) begin n_fail++; $display("FAIL stall_no_repeat: out_valid %b want 0", out_valid); end
  endtask

  task automatic test_kill();
    out_ready = 1'b1;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    in_valid = 1'b1; in_data = 32'd3; kill = 1'b1;
    tick();
    in_valid = 1'b0; kill = 1'b0;
    n_chk++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL kill_to_idle: in_ready %b out_valid %b want 1/0", in_ready, out_valid);
    end
    push(32'd10, 1'b0);
    push(32'd20, 1'b1);
    wait_valid("kill_new");
    n_chk++;
    if (out_data !== 32'd30) begin n_fail++; $display("FAIL kill_new_data: got %0d want 30", out_data); end
    n_chk++;
    if (out_cnt !== 5'd2) begin n_fail++; $display("FAIL kill_new_cnt: got %0d want 2", out_cnt); end
    tick();
    out_ready = 1'b0;
    push(32'd4, 1'b0);
    push(32'd5, 1'b1);
    wait_valid("kill_done");
    kill = 1'b1;
    tick();
    kill = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL kill_in_done: out_valid %b in_ready %b want 0/1", out_valid, in_ready);
    end
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    push(32'd1, 1'b0);
    push(32'd2, 1'b0);
    core_reset = 1'b1;
    tick();
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cnt !== 5'd0 || in_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_accum: valid %b data %h cnt %0d ready %b want 0/0/0/0", out_valid, out_data, out_cnt, in_ready);
    end
    core_reset = 1'b0;
    tick();
    push(32'd6, 1'b1);
    wait_valid("reset_done_pre");
    n_chk++;
    if (out_data !== 32'd6) begin n_fail++; $display("FAIL reset_fresh_data: got %0d want 6", out_data); end
    core_reset = 1'b1;
    tick();
    core_reset = 1'b0;
    n_chk++;
    if (out_valid !== 1'b0 || out_data !== 32'h0 || out_cnt !== 5'd0) begin
      n_fail++;
      $display("FAIL reset_done: valid %b data %h cnt %0d want 0/0/0", out_valid, out_data, out_cnt);
    end
    tick();
  endtask

  task automatic test_random();
    logic [WIDTH-1:0] model_sum;
    logic [WIDTH-1:0] v;
    int               n;
    for (int r = 0; r < 6; r++) begin
      n         = $urandom_range(1, MAX_OPS);
      model_sum = '0;
      out_ready = 1'b0;
      for (int i = 0; i < n; i++) begin
        v         = $urandom();
        model_sum = model_sum + v;
        for (int g = $urandom_range(0, 2); g > 0; g--) tick();
        push(v, (i == n - 1) ? 1'b1 : 1'b0);
      end
      wait_valid("rand");
      for (int g = $urandom_range(0, 3); g > 0; g--) tick();
      n_chk++;
      if (out_data !== model_sum || out_cnt !== CNT_W'(n)) begin
        n_fail++;
        $display("FAIL rand%0d: data %h cnt %0d want %h/%0d", r, out_data, out_cnt, model_sum, n);
      end
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
    end
  endtask

  initial begin
    n_chk      = 0;
    n_fail     = 0;
    core_reset = 1'b1;
    in_valid   = 1'b0;
    in_data    = '0;
    in_last    = 1'b0;
    kill       = 1'b0;
    out_ready  = 1'b0;
    #1;
    test_reset();
    test_basic();
    test_single();
    test_max_ops();
    test_stall_backpressure();
    test_kill();
    test_reset_mid();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
